// File: rtl/ask_frame_sequencer.sv
// Serialises parallel words onto the ASK modulator's carrier-enable line:
// optional 1,0,1,0 preamble, MSB-first data at a programmable bit period, then one carrier-off stop bit.
module ask_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DIV_W-1:0]  bit_period,
  input  logic              preamble_en,
  output logic              modulator,
  output logic              busy,
  output logic              bit_tick,
  output logic              frame_done
);

  localparam int BW = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_PRE_BIT  = BW'(3);

  typedef enum logic [1:0] {IDLE, PRE, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DIV_W-1:0]  period, period_n;
  logic [DIV_W-1:0]  cyc, cyc_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic              last, last_n;
  logic              mod_n, tick_n, done_n;

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign last       = (cyc == period - DIV_W'(1));

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    period_n = period;
    cyc_n    = cyc;
    bitcnt_n = bitcnt;
    case (state)
      IDLE: begin
        if (data_valid) begin
          shreg_n  = data_in;
          period_n = (bit_period == '0) ? DIV_W'(1) : bit_period;
          state_n  = preamble_en ? PRE : DATA;
          cyc_n    = '0;
          bitcnt_n = '0;
        end
      end
      PRE: begin
        if (last) begin
          cyc_n = '0;
          if (bitcnt == LAST_PRE_BIT) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end else begin
          cyc_n = cyc + DIV_W'(1);
        end
      end
      DATA: begin
        if (last) begin
          cyc_n   = '0;
          shreg_n = shreg << 1;
          if (bitcnt == LAST_DATA_BIT) begin
            state_n  = STOP;
            bitcnt_n = '0;
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end else begin
          cyc_n = cyc + DIV_W'(1);
        end
      end
      STOP: begin
        if (last) begin
          state_n = IDLE;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_comb begin
    last_n = (cyc_n == period_n - DIV_W'(1));
    tick_n = (state_n != IDLE) && last_n;
    done_n = (state_n == STOP) && last_n;
    case (state_n)
      PRE:     mod_n = ~bitcnt_n[0];
      DATA:    mod_n = shreg_n[DATA_W-1];
      default: mod_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      period     <= '0;
      cyc        <= '0;
      bitcnt     <= '0;
      modulator  <= 1'b0;
      bit_tick   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      period     <= period_n;
      cyc        <= cyc_n;
      bitcnt     <= bitcnt_n;
      modulator  <= mod_n;
      bit_tick   <= tick_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_ask_frame_sequencer.sv
// Directed self-checking bench for ask_frame_sequencer: expected bit streams and
// tick/done timing are built independently from the word, period and preamble setting.
module tb_ask_frame_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] bit_period;
  logic        preamble_en;
  logic        modulator;
  logic        busy;
  logic        bit_tick;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  ask_frame_sequencer #(.DATA_W(8), .DIV_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .bit_period  (bit_period),
    .preamble_en (preamble_en),
    .modulator   (modulator),
    .busy        (busy),
    .bit_tick    (bit_tick),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Presents a word and returns positioned in the first cycle after the accepting edge.
  task automatic applyStimulus(input logic [7:0] word, input int per, input bit pre, input bit keepValid);
    int n = 0;
    data_in     = word;
    bit_period  = 16'(per);
    preamble_en = pre;
    data_valid  = 1'b1;
    while (!data_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) checkOutput("accept_timeout", 32'(data_ready), 32'd1);
    step();
    if (!keepValid) data_valid = 1'b0;
  endtask

  // Walks a frame cycle by cycle from cycle 1, then checks the idle cycle that follows frame_done.
  task automatic runFrame(input string tag, input logic [7:0] word, input int per, input bit pre, input bit midChange);
    logic expBits [0:12];
    int nbits, effPer, k, idx, modErr, tickErr, rdyErr, ticks, doneCycle;
    logic expMod, expTick;
    k = 0;
    if (pre) begin
      expBits[0] = 1'b1; expBits[1] = 1'b0; expBits[2] = 1'b1; expBits[3] = 1'b0;
      k = 4;
    end
    for (int i = 0; i < 8; i++) expBits[k+i] = word[7-i];
    expBits[k+8] = 1'b0;
    nbits  = k + 9;
    effPer = (per == 0) ? 1 : per;
    modErr = 0; tickErr = 0; rdyErr = 0; ticks = 0; doneCycle = -1;
    for (int c = 1; c <= nbits * effPer + 50; c++) begin
      idx     = (c - 1) / effPer;
      expMod  = (idx < nbits) ? expBits[idx] : 1'b0;
      expTick = ((c % effPer) == 0);
      if (modulator !== expMod) modErr++;
      if (bit_tick !== expTick) tickErr++;
      if (bit_tick === 1'b1) ticks++;
      if (data_ready !== 1'b0 || busy !== 1'b1) rdyErr++;
      if (frame_done === 1'b1) begin
        doneCycle = c;
        break;
      end
      if (midChange && c == 5) begin
        bit_period = 16'd10;
        data_in    = 8'h00;
      end
      step();
    end
    checkOutput({tag, "_modulator_errors"}, 32'(modErr), 32'd0);
    checkOutput({tag, "_tick_errors"}, 32'(tickErr), 32'd0);
    checkOutput({tag, "_tick_count"}, 32'(ticks), 32'(nbits));
    checkOutput({tag, "_done_cycle"}, 32'(doneCycle), 32'(nbits * effPer));
    checkOutput({tag, "_ready_busy_errors"}, 32'(rdyErr), 32'd0);
    step();
    checkOutput({tag, "_post_ready"}, 32'(data_ready), 32'd1);
    checkOutput({tag, "_post_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_post_done_low"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_post_modulator"}, 32'(modulator), 32'd0);
  endtask

  initial begin
    int ticks, dones, highs;
    reset = 1'b1; data_in = '0; data_valid = 1'b0; bit_period = '0; preamble_en = 1'b0;

    $display("[TB] reset then idle");
    step(); step(); step();
    reset = 1'b0;
    step();
    checkOutput("reset_modulator", 32'(modulator), 32'd0);
    checkOutput("reset_ready", 32'(data_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tick", 32'(bit_tick), 32'd0);
    checkOutput("reset_done", 32'(frame_done), 32'd0);
    ticks = 0; dones = 0; highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bit_tick === 1'b1) ticks++;
      if (frame_done === 1'b1) dones++;
      if (modulator === 1'b1) highs++;
    end
    checkOutput("idle_ticks", 32'(ticks), 32'd0);
    checkOutput("idle_dones", 32'(dones), 32'd0);
    checkOutput("idle_modulator_high", 32'(highs), 32'd0);

    $display("[TB] basic frame 0xA5 period 4");
    applyStimulus(8'hA5, 4, 1'b0, 1'b0);
    runFrame("basic", 8'hA5, 4, 1'b0, 1'b0);

    $display("[TB] preamble with period 0, 0xFF");
    applyStimulus(8'hFF, 0, 1'b1, 1'b0);
    runFrame("pre_p0", 8'hFF, 0, 1'b1, 1'b0);

    $display("[TB] back-to-back 0x3C then 0xC3, period 2");
    applyStimulus(8'h3C, 2, 1'b0, 1'b1);
    data_in = 8'hC3;
    runFrame("b2b_first", 8'h3C, 2, 1'b0, 1'b0);
    step();
    data_valid = 1'b0;
    checkOutput("b2b_second_accepted", 32'(busy), 32'd1);
    runFrame("b2b_second", 8'hC3, 2, 1'b0, 1'b0);

    $display("[TB] mid-frame input change, 0x81 period 3");
    applyStimulus(8'h81, 3, 1'b0, 1'b0);
    runFrame("midchange", 8'h81, 3, 1'b0, 1'b1);

    $display("[TB] reset mid-frame, period 5");
    applyStimulus(8'h5A, 5, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step();
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midreset_modulator", 32'(modulator), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(frame_done), 32'd0);
    checkOutput("midreset_ready", 32'(data_ready), 32'd1);
    dones = 0; ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (frame_done === 1'b1) dones++;
      if (bit_tick === 1'b1) ticks++;
    end
    checkOutput("midreset_no_done", 32'(dones), 32'd0);
    checkOutput("midreset_no_ticks", 32'(ticks), 32'd0);
    applyStimulus(8'hC3, 1, 1'b1, 1'b0);
    runFrame("after_reset", 8'hC3, 1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
